// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: fetch/decode/execute/write-back with load/store,
// branch, jump and halt paths, plus a per-state done-timeout watchdog.
module multicycle_ctrl #(
   parameter int RD_W    = 2,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8,
   localparam int NUM_REGS = 2**RD_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                fetch_done,
   input  logic                alu_done,
   input  logic                mem_done,
   input  logic                zero,
   input  logic [3:0]          opcode,
   input  logic [RD_W-1:0]     rd,
   output logic                fetch_pulse,
   output logic                pc_pulse,
   output logic                group_pulse,
   output logic                mem_pulse,
   output logic                mem_we,
   output logic [1:0]          pc_ctrl,
   output logic [NUM_REGS-1:0] reg_en,
   output logic                alu_in_sel,
   output logic [2:0]          alu_func,
   output logic                halted,
   output logic                error
);

   // state   | meaning
   // INIT    | idle after reset or watchdog abort, waits for start
   // IF      | instruction fetch, waits for fetch_done
   // ID      | decode, one cycle; JMP redirects the PC here
   // EX_AL   | ALU operation, waits for alu_done
   // EX_MEM  | load/store access, waits for mem_done
   // EX_BR   | conditional branch on zero, one cycle
   // WB      | register write-back, one cycle
   // HALT    | stopped, waits for start
   typedef enum logic [2:0] {
      S_INIT, S_IF, S_ID, S_EX_AL, S_EX_MEM, S_EX_BR, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_LD   = 4'b1000;
   localparam logic [3:0] OP_ST   = 4'b1001;
   localparam logic [3:0] OP_BEQZ = 4'b1010;
   localparam logic [3:0] OP_JMP  = 4'b1011;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t          state, state_nxt;
   logic            entry;
   logic            redir;
   logic [TO_W-1:0] wd_cnt;
   logic            wd_hit;
   logic            wd_gated;
   logic            err_set;

   assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == TO_LAST);
   assign wd_gated = (state == S_IF) || (state == S_EX_AL) || (state == S_EX_MEM);

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      case (state)
         S_INIT: if (start) state_nxt = S_IF;
         S_IF: begin
            if (fetch_done) state_nxt = S_ID;
            else if (wd_hit) begin
               state_nxt = S_INIT;
               err_set   = 1'b1;
            end
         end
         S_ID: begin
            if (!opcode[3])                        state_nxt = S_EX_AL;
            else if (opcode == OP_LD || opcode == OP_ST) state_nxt = S_EX_MEM;
            else if (opcode == OP_BEQZ)            state_nxt = S_EX_BR;
            else if (opcode == OP_JMP)             state_nxt = S_IF;
            else if (opcode == OP_HALT)            state_nxt = S_HALT;
            else begin
               state_nxt = S_IF;
               err_set   = 1'b1;
            end
         end
         S_EX_AL: begin
            if (alu_done) state_nxt = S_WB;
            else if (wd_hit) begin
               state_nxt = S_INIT;
               err_set   = 1'b1;
            end
         end
         S_EX_MEM: begin
            if (mem_done) state_nxt = (opcode == OP_ST) ? S_IF : S_WB;
            else if (wd_hit) begin
               state_nxt = S_INIT;
               err_set   = 1'b1;
            end
         end
         S_EX_BR: state_nxt = S_IF;
         S_WB:    state_nxt = S_IF;
         S_HALT:  if (start) state_nxt = S_IF;
         default: state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_INIT;
         entry  <= 1'b0;
         redir  <= 1'b0;
         wd_cnt <= '0;
         error  <= 1'b0;
      end else begin
         state <= state_nxt;
         entry <= (state_nxt != state);
         // A redirected IF must not add its own +1 on top of the target load.
         redir <= ((state == S_ID) && (opcode == OP_JMP)) || ((state == S_EX_BR) && zero);
         if (state_nxt != state)
            wd_cnt <= '0;
         else if ((TIMEOUT != 0) && wd_gated)
            wd_cnt <= wd_cnt + TO_W'(1);
         if (((state == S_INIT) || (state == S_HALT)) && start)
            error <= 1'b0;
         else if (err_set)
            error <= 1'b1;
      end
   end

   always_comb begin
      fetch_pulse = 1'b0;
      pc_pulse    = 1'b0;
      group_pulse = 1'b0;
      mem_pulse   = 1'b0;
      mem_we      = 1'b0;
      pc_ctrl     = 2'b00;
      reg_en      = '0;
      alu_in_sel  = 1'b0;
      alu_func    = 3'b000;
      halted      = 1'b0;
      case (state)
         S_IF: begin
            fetch_pulse = entry;
            if (entry && !redir) begin
               pc_pulse = 1'b1;
               pc_ctrl  = 2'b01;
            end
         end
         S_ID: begin
            if (opcode == OP_JMP) begin
               pc_pulse = 1'b1;
               pc_ctrl  = 2'b11;
            end
         end
         S_EX_AL: begin
            group_pulse = entry;
            case (opcode)
               4'b0001: begin alu_in_sel = 1'b1; alu_func = 3'b001; end
               4'b0010: begin alu_in_sel = 1'b1; alu_func = 3'b010; end
               4'b0011: begin alu_in_sel = 1'b1; alu_func = 3'b011; end
               4'b0100: begin alu_in_sel = 1'b0; alu_func = 3'b000; end
               4'b0101: begin alu_in_sel = 1'b0; alu_func = 3'b010; end
               4'b0110: begin alu_in_sel = 1'b0; alu_func = 3'b100; end
               default: begin alu_in_sel = 1'b1; alu_func = 3'b000; end
            endcase
         end
         S_EX_MEM: begin
            mem_pulse = entry;
            mem_we    = (opcode == OP_ST);
         end
         S_EX_BR: begin
            pc_pulse = zero;
            pc_ctrl  = zero ? 2'b10 : 2'b00;
         end
         S_WB:    reg_en = NUM_REGS'(1) << rd;
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model generates the expected
// output vector for every cycle, and one process compares both DUT builds against it.
module tb_multicycle_ctrl;

   localparam int TO = 5;

   logic       clk = 1'b0;
   logic       rst_n, start, fetch_done, alu_done, mem_done, zero;
   logic [3:0] opcode;
   logic [1:0] rd;

   logic       fetch_pulse, pc_pulse, group_pulse, mem_pulse, mem_we, alu_in_sel, halted, error;
   logic [1:0] pc_ctrl;
   logic [3:0] reg_en;
   logic [2:0] alu_func;

   logic       fetch_pulse_1, pc_pulse_1, group_pulse_1, mem_pulse_1, mem_we_1, alu_in_sel_1, halted_1, error_1;
   logic [1:0] pc_ctrl_1;
   logic [1:0] reg_en_1;
   logic [2:0] alu_func_1;

   multicycle_ctrl #(.RD_W(2), .TIMEOUT(TO), .TO_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fetch_done(fetch_done),
      .alu_done(alu_done), .mem_done(mem_done), .zero(zero), .opcode(opcode), .rd(rd),
      .fetch_pulse(fetch_pulse), .pc_pulse(pc_pulse), .group_pulse(group_pulse),
      .mem_pulse(mem_pulse), .mem_we(mem_we), .pc_ctrl(pc_ctrl), .reg_en(reg_en),
      .alu_in_sel(alu_in_sel), .alu_func(alu_func), .halted(halted), .error(error));

   multicycle_ctrl #(.RD_W(1), .TIMEOUT(TO), .TO_W(4)) dut_1 (
      .clk(clk), .rst_n(rst_n), .start(start), .fetch_done(fetch_done),
      .alu_done(alu_done), .mem_done(mem_done), .zero(zero), .opcode(opcode), .rd(rd[0]),
      .fetch_pulse(fetch_pulse_1), .pc_pulse(pc_pulse_1), .group_pulse(group_pulse_1),
      .mem_pulse(mem_pulse_1), .mem_we(mem_we_1), .pc_ctrl(pc_ctrl_1), .reg_en(reg_en_1),
      .alu_in_sel(alu_in_sel_1), .alu_func(alu_func_1), .halted(halted_1), .error(error_1));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       fp, pp, gp, mp, mw;
      logic [1:0] pcc;
      logic [3:0] re;
      logic [1:0] re1;
      logic       ais;
      logic [2:0] af;
      logic       hl, er;
   } outs_t;

   outs_t expq[$];
   int    tests  = 0;
   int    failed = 0;
   logic  m_err   = 1'b0;
   logic  m_redir = 1'b0;

   outs_t a, e_cmp;
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         e_cmp = expq.pop_front();
         a = '{fetch_pulse, pc_pulse, group_pulse, mem_pulse, mem_we, pc_ctrl, reg_en,
               reg_en_1, alu_in_sel, alu_func, halted, error};
         tests++;
         if (a !== e_cmp) begin
            failed++;
            $display("FAIL cycle_outputs t=%0t op=%b actual=%h required=%h", $time, opcode, a, e_cmp);
         end
         tests++;
         if ({fetch_pulse_1, pc_pulse_1, group_pulse_1, mem_pulse_1, mem_we_1, pc_ctrl_1,
              alu_in_sel_1, alu_func_1, halted_1, error_1} !==
             {e_cmp.fp, e_cmp.pp, e_cmp.gp, e_cmp.mp, e_cmp.mw, e_cmp.pcc,
              e_cmp.ais, e_cmp.af, e_cmp.hl, e_cmp.er}) begin
            failed++;
            $display("FAIL rd_w1_outputs t=%0t actual_err=%b required_err=%b", $time, error_1, e_cmp.er);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic outs_t base();
      outs_t e;
      e = '0;
      e.er = m_err;
      return e;
   endfunction

   function automatic outs_t mk(input logic fp, pp, gp, mp, mw, input logic [1:0] pcc,
                                input logic [3:0] re, input logic [1:0] re1, input logic ais,
                                input logic [2:0] af, input logic hl, er);
      return '{fp, pp, gp, mp, mw, pcc, re, re1, ais, af, hl, er};
   endfunction

   // ALU op -> {register operand select, function code} from the opcode table
   function automatic logic [3:0] alu_model(input logic [3:0] op);
      case (op)
         4'd1: return {1'b1, 3'd1};
         4'd2: return {1'b1, 3'd2};
         4'd3: return {1'b1, 3'd3};
         4'd4: return {1'b0, 3'd0};
         4'd5: return {1'b0, 3'd2};
         4'd6: return {1'b0, 3'd4};
         default: return {1'b1, 3'd0};
      endcase
   endfunction

   task automatic tick(input logic st, fd, ad, md, z, input logic [3:0] op,
                       input logic [1:0] r, input outs_t e);
      @(posedge clk);
      #1;
      start = st; fetch_done = fd; alu_done = ad; mem_done = md; zero = z;
      opcode = op; rd = r;
      expq.push_back(e);
   endtask

   task automatic do_init(input logic [3:0] op, input logic [1:0] r);
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) tick(1'b0, rb(), rb(), rb(), rb(), op, r, base());
      tick(1'b1, rb(), rb(), rb(), rb(), op, r, base());
      m_err = 1'b0;
      m_redir = 1'b0;
   endtask

   // Runs one instruction starting from its first IF cycle; returns with the next
   // cycle being a fresh IF entry.
   task automatic run_instr(input logic [3:0] op, input logic [1:0] r, input int fdel,
                            input int xdel, input logic zv, input int hdel);
      outs_t e;
      logic [3:0] af;
      for (int i = 0; i < TO; i++) begin
         e = base();
         if (i == 0) begin
            e.fp = 1'b1;
            if (!m_redir) begin e.pp = 1'b1; e.pcc = 2'b01; end
         end
         if (i == fdel) begin
            tick(rb(), 1'b1, rb(), rb(), rb(), op, r, e);
            break;
         end
         tick(rb(), 1'b0, rb(), rb(), rb(), op, r, e);
         if (i == TO - 1) begin m_err = 1'b1; do_init(op, r); return; end
      end
      m_redir = 1'b0;
      e = base();
      if (op == 4'b1011) begin e.pp = 1'b1; e.pcc = 2'b11; end
      tick(rb(), rb(), rb(), rb(), rb(), op, r, e);
      if (!op[3]) begin
         af = alu_model(op);
         for (int i = 0; i < TO; i++) begin
            e = base(); e.gp = (i == 0); e.ais = af[3]; e.af = af[2:0];
            if (i == xdel) begin tick(rb(), rb(), 1'b1, rb(), rb(), op, r, e); break; end
            tick(rb(), rb(), 1'b0, rb(), rb(), op, r, e);
            if (i == TO - 1) begin m_err = 1'b1; do_init(op, r); return; end
         end
         e = base(); e.re = 4'(1) << r; e.re1 = 2'(1) << r[0];
         tick(rb(), rb(), rb(), rb(), rb(), op, r, e);
      end else if (op == 4'b1000 || op == 4'b1001) begin
         for (int i = 0; i < TO; i++) begin
            e = base(); e.mp = (i == 0); e.mw = (op == 4'b1001);
            if (i == xdel) begin tick(rb(), rb(), rb(), 1'b1, rb(), op, r, e); break; end
            tick(rb(), rb(), rb(), 1'b0, rb(), op, r, e);
            if (i == TO - 1) begin m_err = 1'b1; do_init(op, r); return; end
         end
         if (op == 4'b1000) begin
            e = base(); e.re = 4'(1) << r; e.re1 = 2'(1) << r[0];
            tick(rb(), rb(), rb(), rb(), rb(), op, r, e);
         end
      end else if (op == 4'b1010) begin
         e = base(); e.pp = zv; e.pcc = zv ? 2'b10 : 2'b00;
         tick(rb(), rb(), rb(), rb(), zv, op, r, e);
         m_redir = zv;
      end else if (op == 4'b1011) begin
         m_redir = 1'b1;
      end else if (op == 4'b1111) begin
         e = base(); e.hl = 1'b1;
         for (int i = 0; i < hdel; i++) tick(1'b0, rb(), rb(), rb(), rb(), op, r, e);
         tick(1'b1, rb(), rb(), rb(), rb(), op, r, e);
         m_err = 1'b0;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic reset_in_exal();
      outs_t e;
      e = base(); e.fp = 1'b1;
      if (!m_redir) begin e.pp = 1'b1; e.pcc = 2'b01; end
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, e);
      m_redir = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, base());
      e = base(); e.gp = 1'b1; e.ais = 1'b1; e.af = 3'b011;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, e);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {15'd0, fetch_pulse, pc_pulse, group_pulse, mem_pulse, mem_we,
          pc_ctrl, reg_en, alu_in_sel, alu_func, halted, error}, 32'd0);
      chk("async_reset_rd_w1_reg_en", {30'd0, reg_en_1}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_err = 1'b0;
      m_redir = 1'b0;
      do_init(4'b0011, 2'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; fetch_done = 1'b0; alu_done = 1'b0; mem_done = 1'b0;
      zero = 1'b0; opcode = 4'd0; rd = 2'd0;
      #12;
      chk("reset_outputs", {15'd0, fetch_pulse, pc_pulse, group_pulse, mem_pulse, mem_we,
          pc_ctrl, reg_en, alu_in_sel, alu_func, halted, error}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // hand-computed SUB sequence, rd=2, fetch_done on third IF cycle, alu_done on second
      tick(0, 0, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0000,2'b00,0,3'b000,0,0));
      tick(1, 0, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0000,2'b00,0,3'b000,0,0));
      tick(0, 0, 0, 0, 0, 4'b0001, 2'd2, mk(1,1,0,0,0,2'b01,4'b0000,2'b00,0,3'b000,0,0));
      tick(0, 0, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0000,2'b00,0,3'b000,0,0));
      tick(0, 1, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0000,2'b00,0,3'b000,0,0));
      tick(0, 0, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0000,2'b00,0,3'b000,0,0));
      tick(0, 0, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,1,0,0,2'b00,4'b0000,2'b00,1,3'b001,0,0));
      tick(0, 0, 1, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0000,2'b00,1,3'b001,0,0));
      tick(0, 0, 0, 0, 0, 4'b0001, 2'd2, mk(0,0,0,0,0,2'b00,4'b0100,2'b01,0,3'b000,0,0));
      m_err = 1'b0;
      m_redir = 1'b0;

      run_instr(4'b1000, 2'd1, 0, 3, 1'b0, 0);   // LD, mem_done on 4th cycle
      run_instr(4'b1001, 2'd0, 1, 1, 1'b0, 0);   // ST
      run_instr(4'b1010, 2'd0, 0, 0, 1'b1, 0);   // BEQZ taken
      run_instr(4'b1010, 2'd0, 0, 0, 1'b0, 0);   // BEQZ not taken
      run_instr(4'b1011, 2'd3, 0, 0, 1'b0, 0);   // JMP
      run_instr(4'b0110, 2'd3, TO - 1, TO - 1, 1'b0, 0); // done on the last allowed cycle
      run_instr(4'b0100, 2'd3, TO + 2, 0, 1'b0, 0);   // fetch timeout
      run_instr(4'b0000, 2'd0, 0, TO + 3, 1'b0, 0);   // ALU timeout
      run_instr(4'b1000, 2'd2, 0, TO + 1, 1'b0, 0);   // memory timeout
      run_instr(4'b1111, 2'd0, 0, 0, 1'b0, 2);        // HALT
      run_instr(4'b1101, 2'd0, 0, 0, 1'b0, 0);        // illegal
      run_instr(4'b0111, 2'd3, 0, 0, 1'b0, 0);        // reserved -> ADD, error still set
      run_instr(4'b1111, 2'd1, 0, 0, 1'b0, 0);        // HALT + start clears error
      reset_in_exal();

      for (int n = 0; n < 300; n++) begin
         run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1)),
                   ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, TO - 1)),
                   rb(), int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
